// File: rtl/whack_game_core.sv
// Whack-a-mole game engine: LFSR mole placement, guess scoring, per-mole timeout, lives and game FSM.
// Optional build macro WHACK_SPEEDUP_EN: timeout shrinks by one every 4th hit, down to MIN_TIMEOUT.
module whack_game_core #(
  parameter int          NUM_HOLES   = 8,
  parameter int          POS_W       = 3,
  parameter int          SCORE_W     = 8,
  parameter int          LIVES       = 3,
  parameter int          TIMEOUT     = 16,
  parameter int          MIN_TIMEOUT = 4,
  parameter logic [15:0] LFSR_SEED   = 16'hACE1
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic                 tick,
  input  logic                 start,
  input  logic [POS_W-1:0]     user_guess,
  input  logic                 eval_now,
  output logic [POS_W-1:0]     mole_pos,
  output logic                 mole_change,
  output logic                 guess_correct,
  output logic                 guess_wrong,
  output logic                 missed,
  output logic [SCORE_W-1:0]   score,
  output logic [3:0]           lives,
  output logic                 game_over,
  output logic [NUM_HOLES-1:0] led
);

  // Timer wide enough for whichever of the two timeout limits is larger.
  localparam int TMR_W = $clog2(((TIMEOUT > MIN_TIMEOUT) ? TIMEOUT : MIN_TIMEOUT) + 1);
  localparam logic [POS_W:0]     HOLES_EXT = (POS_W+1)'(NUM_HOLES);
  localparam logic [TMR_W-1:0]   TIMEOUT_V = TMR_W'(TIMEOUT);
  localparam logic [3:0]         LIVES_V   = 4'(LIVES);
  localparam logic [SCORE_W-1:0] SCORE_MAX = '1;

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_PLAY = 2'd1,
    S_OVER = 2'd2
  } state_t;

  state_t             state, state_next;
  logic [15:0]        lfsr;
  logic [TMR_W-1:0]   timer, timer_next, cur_timeout;
  logic [POS_W-1:0]   mole_pos_next, wrong_pos, wrong_pos_next;
  logic [POS_W-1:0]   cand, new_pos;
  logic [SCORE_W-1:0] score_next;
  logic [3:0]         lives_next;
  logic               change_next, correct_next, wrong_next, missed_next;
  logic               enter_play, hit_evt;

  function automatic logic [POS_W-1:0] wrap_pos(input logic [POS_W:0] v);
    logic [POS_W:0] r;
    r = v % HOLES_EXT;
    return r[POS_W-1:0];
  endfunction

  // Candidate from the LFSR; bump by one if it lands on the current hole so the mole always moves.
  always_comb begin
    cand    = wrap_pos({1'b0, lfsr[POS_W-1:0]});
    new_pos = (cand == mole_pos) ? wrap_pos({1'b0, mole_pos} + 1'b1) : cand;
  end

`ifdef WHACK_SPEEDUP_EN
  localparam logic [TMR_W-1:0] MIN_V = TMR_W'(MIN_TIMEOUT);
  logic [1:0] hit_cnt;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      hit_cnt     <= 2'd0;
      cur_timeout <= TIMEOUT_V;
    end else if (enter_play) begin
      hit_cnt     <= 2'd0;
      cur_timeout <= TIMEOUT_V;
    end else if (hit_evt) begin
      hit_cnt <= hit_cnt + 2'd1;
      if (hit_cnt == 2'd3 && cur_timeout > MIN_V)
        cur_timeout <= cur_timeout - 1'b1;
    end
  end
`else
  assign cur_timeout = TIMEOUT_V;
`endif

  always_comb begin
    state_next     = state;
    mole_pos_next  = mole_pos;
    score_next     = score;
    lives_next     = lives;
    timer_next     = timer;
    wrong_pos_next = wrong_pos;
    change_next    = 1'b0;
    correct_next   = 1'b0;
    wrong_next     = 1'b0;
    missed_next    = 1'b0;
    enter_play     = 1'b0;
    hit_evt        = 1'b0;
    case (state)
      S_IDLE, S_OVER: begin
        if (start) begin
          enter_play    = 1'b1;
          state_next    = S_PLAY;
          score_next    = '0;
          lives_next    = LIVES_V;
          timer_next    = '0;
          mole_pos_next = new_pos;
          change_next   = 1'b1;
        end
      end
      S_PLAY: begin
        // An evaluation in the same cycle as a timeout tick takes priority and swallows the tick.
        if (eval_now) begin
          if (user_guess == mole_pos) begin
            hit_evt       = 1'b1;
            correct_next  = 1'b1;
            score_next    = (score == SCORE_MAX) ? score : score + 1'b1;
            mole_pos_next = new_pos;
            change_next   = 1'b1;
            timer_next    = '0;
          end else begin
            wrong_next     = 1'b1;
            wrong_pos_next = user_guess;
            lives_next     = lives - 1'b1;
            if (lives == 4'd1)
              state_next = S_OVER;
          end
        end else if (tick) begin
          if (timer == cur_timeout - 1'b1) begin
            missed_next = 1'b1;
            lives_next  = lives - 1'b1;
            timer_next  = '0;
            if (lives == 4'd1) begin
              state_next = S_OVER;
            end else begin
              mole_pos_next = new_pos;
              change_next   = 1'b1;
            end
          end else begin
            timer_next = timer + 1'b1;
          end
        end
      end
      default: state_next = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state         <= S_IDLE;
      lfsr          <= LFSR_SEED;
      mole_pos      <= '0;
      score         <= '0;
      lives         <= LIVES_V;
      timer         <= '0;
      wrong_pos     <= '0;
      mole_change   <= 1'b0;
      guess_correct <= 1'b0;
      guess_wrong   <= 1'b0;
      missed        <= 1'b0;
    end else begin
      state         <= state_next;
      lfsr          <= {lfsr[14:0], lfsr[15] ^ lfsr[13] ^ lfsr[12] ^ lfsr[10]};
      mole_pos      <= mole_pos_next;
      score         <= score_next;
      lives         <= lives_next;
      timer         <= timer_next;
      wrong_pos     <= wrong_pos_next;
      mole_change   <= change_next;
      guess_correct <= correct_next;
      guess_wrong   <= wrong_next;
      missed        <= missed_next;
    end
  end

  assign game_over = (state == S_OVER);

  // Display: mole lamp, plus the wrongly guessed lamp for the one cycle guess_wrong is up.
  always_comb begin
    led = '0;
    if (state == S_OVER) begin
      led = '1;
    end else if (state == S_PLAY) begin
      for (int i = 0; i < NUM_HOLES; i++)
        led[i] = (mole_pos == POS_W'(i)) || (guess_wrong && wrong_pos == POS_W'(i));
    end
  end

endmodule
